// File: rtl/penc_pkg.sv
// Shared types and helpers for the 8-to-3 event encoder.
// Request vector/index typedefs, load-mask and popcount helpers.
package penc_pkg;

  localparam int N_IN  = 8;
  localparam int IDX_W = 3;

  typedef logic [N_IN-1:0]  req_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic req_t onehot8(input idx_t idx);
    return req_t'(1) << idx;
  endfunction

  // More than one bit set: clearing the lowest set bit leaves something.
  function automatic logic popcnt_gt1(input req_t vec);
    return (vec & (vec - req_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/penc_83_comb.sv
// Combinational 8:3 priority encoder.
// Ports: vec_i, prio_high_i (1: highest index wins) -> idx_o, any_o.
module penc_83_comb
  import penc_pkg::*;
(
  input  req_t vec_i,
  input  logic prio_high_i,
  output idx_t idx_o,
  output logic any_o
);

  // Later loop iterations override earlier ones, so scan order sets priority.
  always_comb begin
    idx_o = '0;
    if (prio_high_i) begin
      for (int i = 0; i < N_IN; i++)
        if (vec_i[i]) idx_o = idx_t'(i);
    end else begin
      for (int i = N_IN - 1; i >= 0; i--)
        if (vec_i[i]) idx_o = idx_t'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/penc_823_evt.sv
// Sequential 8-to-3 event encoder with valid/ready output slot.
// Ports: clk, rst_n, req_i, out_rdy_i, clr_ovf_i -> out_vld_o, out_idx_o, more_o, ovf_o.
module penc_823_evt
  import penc_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req_i,
  input  logic             out_rdy_i,
  input  logic             clr_ovf_i,
  output logic             out_vld_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             more_o,
  output logic             ovf_o
);

  req_t pend_q, pend_d;
  logic vld_q, vld_d;
  idx_t idx_q, idx_d;
  logic more_q, more_d;
  logic ovf_q, ovf_d;

  idx_t sel;
  logic any;
  logic free;
  logic load;
  req_t load_mask;

  penc_83_comb u_enc (
    .vec_i       (pend_q),
    .prio_high_i (PRIO_HIGH),
    .idx_o       (sel),
    .any_o       (any)
  );

  always_comb begin
    free      = !vld_q | out_rdy_i;
    load      = free & any;
    load_mask = load ? onehot8(sel) : '0;
    // Set wins over clear: a fresh request on the loaded line re-pends it.
    pend_d    = (pend_q & ~load_mask) | req_i;
    vld_d     = free ? any : vld_q;
    idx_d     = load ? sel : idx_q;
    more_d    = load ? popcnt_gt1(pend_q) : more_q;
    // A same-edge duplicate beats the clear.
    ovf_d     = (|(req_i & pend_q & ~load_mask))
              | (ovf_q & ~clr_ovf_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      more_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      more_q <= more_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_vld_o = vld_q;
  assign out_idx_o = idx_q;
  assign more_o    = more_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_penc_823_evt.sv
// Bench for penc_823_evt: high- and low-priority instances on shared inputs,
// directed scenarios plus random traffic against a behavioural model.
module tb_penc_823_evt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;

  logic       vld_h, vld_l;
  logic [2:0] idx_h, idx_l;
  logic       more_h, more_l;
  logic       ovf_h, ovf_l;

  int checks = 0;
  int failures = 0;

  // Model state, [0] = highest-wins, [1] = lowest-wins.
  logic [7:0] m_pend [2];
  logic       m_vld  [2];
  int         m_idx  [2];
  logic       m_more [2];
  logic       m_ovf  [2];

  always #5 clk = ~clk;

  penc_823_evt #(.PRIO_HIGH(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .req_i(req), .out_rdy_i(rdy),
    .clr_ovf_i(clr), .out_vld_o(vld_h), .out_idx_o(idx_h),
    .more_o(more_h), .ovf_o(ovf_h)
  );

  penc_823_evt #(.PRIO_HIGH(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .req_i(req), .out_rdy_i(rdy),
    .clr_ovf_i(clr), .out_vld_o(vld_l), .out_idx_o(idx_l),
    .more_o(more_l), .ovf_o(ovf_l)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = '0;
      m_vld[p]  = 1'b0;
      m_idx[p]  = 0;
      m_more[p] = 1'b0;
      m_ovf[p]  = 1'b0;
    end
  endtask

  function automatic int pick(input int p, input logic [7:0] v);
    int r;
    r = -1;
    if (p == 0) begin
      for (int i = 7; i >= 0; i--)
        if (v[i] && r < 0) r = i;
    end else begin
      for (int i = 0; i < 8; i++)
        if (v[i] && r < 0) r = i;
    end
    return r;
  endfunction

  task automatic model_edge();
    for (int p = 0; p < 2; p++) begin
      int  ld;
      int  cnt;
      bit  slot_free;
      bit  dup;
      ld = -1;
      cnt = 0;
      dup = 0;
      slot_free = !m_vld[p] || rdy;
      for (int i = 0; i < 8; i++) cnt += int'(m_pend[p][i]);
      if (slot_free && cnt > 0) begin
        ld        = pick(p, m_pend[p]);
        m_vld[p]  = 1'b1;
        m_idx[p]  = ld;
        m_more[p] = (cnt > 1);
      end else if (slot_free) begin
        m_vld[p] = 1'b0;
      end
      for (int i = 0; i < 8; i++)
        if (req[i] && m_pend[p][i] && i != ld) dup = 1;
      if (dup) m_ovf[p] = 1'b1;
      else if (clr) m_ovf[p] = 1'b0;
      for (int i = 0; i < 8; i++)
        m_pend[p][i] = (m_pend[p][i] && i != ld) || req[i];
    end
  endtask

  task automatic check_model();
    chk("vld_hi",  {7'd0, vld_h},  {7'd0, m_vld[0]});
    chk("idx_hi",  {5'd0, idx_h},  8'(m_idx[0]));
    chk("more_hi", {7'd0, more_h}, {7'd0, m_more[0]});
    chk("ovf_hi",  {7'd0, ovf_h},  {7'd0, m_ovf[0]});
    chk("vld_lo",  {7'd0, vld_l},  {7'd0, m_vld[1]});
    chk("idx_lo",  {5'd0, idx_l},  8'(m_idx[1]));
    chk("more_lo", {7'd0, more_l}, {7'd0, m_more[1]});
    chk("ovf_lo",  {7'd0, ovf_l},  {7'd0, m_ovf[1]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drain();
    req = '0;
    rdy = 1'b1;
    clr = 1'b1;
    for (int i = 0; i < 10; i++) step();
    clr = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    chk("por_vld", {7'd0, vld_h}, 8'd0);
    chk("por_ovf", {7'd0, ovf_h}, 8'd0);
    #1 rst_n = 1'b1;

    // Single event
    rdy = 1'b1;
    req = 8'h20;
    step();
    req = 8'h00;
    step();
    chk("single_vld",  {7'd0, vld_h},  8'd1);
    chk("single_idx",  {5'd0, idx_h},  8'd5);
    chk("single_more", {7'd0, more_h}, 8'd0);
    step();
    chk("single_end",  {7'd0, vld_h},  8'd0);

    // Burst on all lines
    req = 8'hFF;
    step();
    req = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("burst_idx_hi",  {5'd0, idx_h}, 8'(7 - k));
      chk("burst_idx_lo",  {5'd0, idx_l}, 8'(k));
      chk("burst_more_hi", {7'd0, more_h}, {7'd0, k != 7});
      chk("burst_vld_lo",  {7'd0, vld_l}, 8'd1);
    end
    step();
    chk("burst_end", {7'd0, vld_h}, 8'd0);

    // Backpressure
    rdy = 1'b0;
    req = 8'h0C;
    step();
    req = 8'h00;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_vld", {7'd0, vld_h}, 8'd1);
      chk("bp_idx", {5'd0, idx_h}, 8'd3);
    end
    rdy = 1'b1;
    step();
    chk("bp_next", {5'd0, idx_h}, 8'd2);
    step();
    chk("bp_done", {7'd0, vld_h}, 8'd0);

    // Overflow while slot holds index 4
    rdy = 1'b0;
    req = 8'h10;
    step();
    req = 8'h00;
    step();
    req = 8'h01;
    step();
    chk("ovf_pre", {7'd0, ovf_h}, 8'd0);
    step();
    chk("ovf_set", {7'd0, ovf_h}, 8'd1);
    chk("ovf_hold_idx", {5'd0, idx_h}, 8'd4);
    req = 8'h00;
    clr = 1'b1;
    step();
    chk("ovf_clr", {7'd0, ovf_h}, 8'd0);
    clr = 1'b0;
    rdy = 1'b1;
    step();
    chk("ovf_idx0", {5'd0, idx_h}, 8'd0);
    chk("ovf_vld0", {7'd0, vld_h}, 8'd1);
    step();
    chk("ovf_once", {7'd0, vld_h}, 8'd0);

    // Set-over-clear on index 6
    req = 8'h40;
    step();
    step();
    chk("soc_first", {5'd0, idx_h}, 8'd6);
    req = 8'h00;
    step();
    chk("soc_again", {5'd0, idx_h}, 8'd6);
    chk("soc_vld",   {7'd0, vld_h}, 8'd1);
    chk("soc_ovf",   {7'd0, ovf_h}, 8'd0);
    step();
    chk("soc_end",   {7'd0, vld_h}, 8'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      step();
    end
    drain();

    // Async reset mid-transfer: pending=A5, slot valid
    rdy = 1'b0;
    req = 8'h01;
    step();
    req = 8'hA5;
    step();
    req = 8'h00;
    chk("rst_pre_vld", {7'd0, vld_h}, 8'd1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_vld_hi",  {7'd0, vld_h},  8'd0);
    chk("rst_idx_hi",  {5'd0, idx_h},  8'd0);
    chk("rst_more_hi", {7'd0, more_h}, 8'd0);
    chk("rst_ovf_hi",  {7'd0, ovf_h},  8'd0);
    chk("rst_vld_lo",  {7'd0, vld_l},  8'd0);
    #2 rst_n = 1'b1;
    rdy = 1'b1;
    step();
    chk("rst_rel1", {7'd0, vld_h}, 8'd0);
    step();
    chk("rst_rel2", {7'd0, vld_h}, 8'd0);
    chk("rst_rel2_lo", {7'd0, vld_l}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
